retire_trace_buffer: RTL

- Captures every committed instruction from the writeback stage of the RISC-V core: PC, write enable, destination and data.
- Entries are queued in a parametrised first-word-fall-through FIFO and drained by the trace sink through a valid/ready handshake.
- Also provides sticky overflow flags, a drop counter and a commit watchdog, so that a hung or over-run core is flagged in hardware rather than silently losing trace lines.

---
 rtl/retire_trace_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures committed instructions into a first-word-fall-through FIFO
// drained by a valid/ready sink, with sticky overflow, drop counter and commit watchdog.
module retire_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIMEOUT   = 1024,
  parameter bit          FILTER_X0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       w_valid,
  input  logic [XLEN-1:0]            w_pc,
  input  logic                       w_enable,
  input  logic [RADDR_W-1:0]         w_destination,
  input  logic [XLEN-1:0]            w_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_wen,
  output logic [RADDR_W-1:0]         out_rd,
  output logic [XLEN-1:0]            out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       timeout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic               wen;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } entry_t;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_ARMED,
    WD_EXPIRED
  } wd_state_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [15:0]       r_drop_count;
  logic              r_timeout;
  wd_state_t         r_wd_state;
  logic [WD_W-1:0]   r_wd_cnt;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  entry_t            w_entry;
  entry_t            w_head;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = w_valid && (!w_full || w_pop);
  assign w_drop = w_valid && w_full && !w_pop;

  // Writes to x0 are architecturally void, so optionally strip them from the trace.
  always_comb begin
    w_entry.pc   = w_pc;
    w_entry.rd   = w_destination;
    w_entry.wen  = w_enable;
    w_entry.data = w_data;
    if (FILTER_X0 && (w_destination == '0)) begin
      w_entry.wen  = 1'b0;
      w_entry.data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy disambiguates full/empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
    end
  end

  // Commit watchdog: counts idle cycles since the last commit once the core has started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_state <= WD_IDLE;
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else if (clear) begin
      r_wd_state <= WD_IDLE;
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_wd_state)
        WD_IDLE: begin
          if (w_valid) begin
            r_wd_state <= WD_ARMED;
            r_wd_cnt   <= '0;
          end
        end
        WD_ARMED: begin
          if (w_valid) begin
            r_wd_cnt <= '0;
          end else if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
            r_wd_cnt   <= r_wd_cnt + WD_W'(1);
            r_timeout  <= 1'b1;
            r_wd_state <= WD_EXPIRED;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        WD_EXPIRED: begin
          if (w_valid) begin
            r_wd_state <= WD_ARMED;
            r_wd_cnt   <= '0;
          end
        end
        default: begin
          r_wd_state <= WD_IDLE;
          r_wd_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_count != '0);
  assign out_pc     = w_head.pc;
  assign out_wen    = w_head.wen;
  assign out_rd     = w_head.rd;
  assign out_data   = w_head.data;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign timeout    = r_timeout;

endmodule
